// File: rtl/seq_detector_prog.sv
// Programmable serial bit-pattern detector with runtime pattern/length/overlap,
// sample enable, saturating match counter and history fill status.
module seq_detector_prog #(
    parameter int unsigned         MAX_LEN     = 8,
    parameter int unsigned         LEN_W       = $clog2(MAX_LEN) + 1,
    parameter int unsigned         CNT_W       = 8,
    parameter logic [MAX_LEN-1:0]  RST_PATTERN = MAX_LEN'(8'b0000_1010),
    parameter int unsigned         RST_LEN     = 4,
    parameter logic                RST_OVERLAP = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               x,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               z,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               primed
);

    localparam logic [LEN_W-1:0] MaxLenL = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CntMax  = '1;

    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               z_q, z_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;

    logic [MAX_LEN-1:0] hist_n;
    logic [LEN_W-1:0]   fill_n;
    logic [MAX_LEN-1:0] len_mask;
    logic               hit;

    // Candidate history after a sample and the match decision on it
    always_comb begin
        hist_n = {hist_q[MAX_LEN-2:0], x};
        fill_n = (fill_q >= MaxLenL) ? MaxLenL : fill_q + LEN_W'(1);
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (LEN_W'(i) < len_q);
        end
        hit = (len_q != '0) && (fill_n >= len_q) &&
              ((hist_n & len_mask) == (pat_q & len_mask));
    end

    // Next-state: cfg_load beats sampling and cnt_clr; idle edges hold history
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        z_d    = 1'b0;
        cnt_d  = cnt_q;
        pat_d  = pat_q;
        len_d  = len_q;
        ovl_d  = ovl_q;
        if (cfg_load) begin
            pat_d  = cfg_pattern;
            len_d  = (cfg_len > MaxLenL) ? MaxLenL : cfg_len;
            ovl_d  = cfg_overlap;
            hist_d = '0;
            fill_d = '0;
            cnt_d  = '0;
        end else begin
            if (en) begin
                hist_d = hist_n;
                z_d    = hit;
                fill_d = (hit && !ovl_q) ? '0 : fill_n;
            end
            if (cnt_clr) begin
                cnt_d = '0;
            end else if (en && hit && (cnt_q != CntMax)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            fill_q <= '0;
            z_q    <= 1'b0;
            cnt_q  <= '0;
            pat_q  <= RST_PATTERN;
            len_q  <= LEN_W'(RST_LEN);
            ovl_q  <= RST_OVERLAP;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            z_q    <= z_d;
            cnt_q  <= cnt_d;
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
        end
    end

    assign z         = z_q;
    assign match_cnt = cnt_q;
    assign primed    = (len_q != '0) && (fill_q >= len_q);

endmodule
